// File: rtl/seg_scan_driver.sv
// Multiplexed 4-digit seven-segment scanner with per-frame shadowed inputs
// and 16-level PWM brightness; all outputs are registered.
module seg_scan_driver #(
    parameter int unsigned SUB_DIV = 3125
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] digitData,
    input  logic [3:0]  dpMask,
    input  logic [3:0]  blankMask,
    input  logic [3:0]  brightness,
    output logic [7:0]  SEG,
    output logic [3:0]  SEGCS,
    output logic        frameStart
);

    localparam int unsigned CW = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;

    logic [CW-1:0] r_subCnt;
    logic [3:0]    r_pwm;
    logic [1:0]    r_index;
    logic [15:0]   r_digitShadow;
    logic [3:0]    r_dpShadow;
    logic [3:0]    r_blankShadow;
    logic [3:0]    r_brightShadow;
    logic [7:0]    r_seg;
    logic [3:0]    r_segcs;
    logic          r_frameStart;

    logic          w_subTick;
    logic          w_slotEnd;
    logic          w_frameEnd;
    logic          w_on;
    logic [3:0]    w_nibble;
    logic [6:0]    w_segs;

    assign w_subTick  = (r_subCnt == CW'(SUB_DIV - 1));
    assign w_slotEnd  = w_subTick && (r_pwm == 4'hF);
    assign w_frameEnd = w_slotEnd && (r_index == 2'd3);
    assign w_on       = (r_pwm <= r_brightShadow) && !r_blankShadow[r_index];

    always_comb begin
        w_nibble = '0;
        case (r_index)
            2'd0: w_nibble = r_digitShadow[3:0];
            2'd1: w_nibble = r_digitShadow[7:4];
            2'd2: w_nibble = r_digitShadow[11:8];
            2'd3: w_nibble = r_digitShadow[15:12];
            default: w_nibble = '0;
        endcase
    end

    // Segment order g..a, bit0 = a.
    always_comb begin
        w_segs = '0;
        case (w_nibble)
            4'h0: w_segs = 7'h3F;
            4'h1: w_segs = 7'h06;
            4'h2: w_segs = 7'h5B;
            4'h3: w_segs = 7'h4F;
            4'h4: w_segs = 7'h66;
            4'h5: w_segs = 7'h6D;
            4'h6: w_segs = 7'h7D;
            4'h7: w_segs = 7'h07;
            4'h8: w_segs = 7'h7F;
            4'h9: w_segs = 7'h6F;
            4'hA: w_segs = 7'h77;
            4'hB: w_segs = 7'h7C;
            4'hC: w_segs = 7'h39;
            4'hD: w_segs = 7'h5E;
            4'hE: w_segs = 7'h79;
            4'hF: w_segs = 7'h71;
            default: w_segs = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_subCnt       <= '0;
            r_pwm          <= '0;
            r_index        <= '0;
            r_digitShadow  <= '0;
            r_dpShadow     <= '0;
            r_blankShadow  <= '0;
            r_brightShadow <= '0;
            r_seg          <= '0;
            r_segcs        <= '1;
            r_frameStart   <= 1'b0;
        end else begin
            r_subCnt <= w_subTick ? '0 : r_subCnt + 1'b1;
            if (w_subTick) r_pwm   <= r_pwm + 1'b1;
            if (w_slotEnd) r_index <= r_index + 1'b1;
            // Shadows load on the same edge the counters wrap to digit 0.
            if (w_frameEnd) begin
                r_digitShadow  <= digitData;
                r_dpShadow     <= dpMask;
                r_blankShadow  <= blankMask;
                r_brightShadow <= brightness;
            end
            r_frameStart <= w_frameEnd;
            r_segcs      <= w_on ? ~(4'b0001 << r_index) : '1;
            r_seg        <= w_on ? {r_dpShadow[r_index], w_segs} : '0;
        end
    end

    assign SEG        = r_seg;
    assign SEGCS      = r_segcs;
    assign frameStart = r_frameStart;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver: a cycle-count based reference model
// predicts each registered output; a negedge monitor pops and compares.
module tb_seg_scan_driver;

    localparam int unsigned SD    = 2;
    localparam int unsigned FRAME = 64 * SD;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digitData = '0;
    logic [3:0]  dpMask = '0;
    logic [3:0]  blankMask = '0;
    logic [3:0]  brightness = '0;
    logic [7:0]  SEG;
    logic [3:0]  SEGCS;
    logic        frameStart;

    seg_scan_driver #(.SUB_DIV(SD)) dut (
        .clk        (clk),
        .rst        (rst),
        .digitData  (digitData),
        .dpMask     (dpMask),
        .blankMask  (blankMask),
        .brightness (brightness),
        .SEG        (SEG),
        .SEGCS      (SEGCS),
        .frameStart (frameStart)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int pops  = 0;

    typedef struct packed {
        logic [7:0] seg;
        logic [3:0] cs;
        logic       fs;
    } exp_t;

    exp_t sb[$];

    logic [6:0] dec [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Reference model: counter state derived from cycles since reset release.
    int unsigned c;
    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_blank, m_bright;

    always @(posedge clk or posedge rst) begin : model
        int unsigned pw, ix;
        logic [3:0]  nib;
        exp_t        e;
        if (rst) begin
            c        = 0;
            m_dig    = '0;
            m_dp     = '0;
            m_blank  = '0;
            m_bright = '0;
            sb.delete();
        end else begin
            pw  = (c / SD) % 16;
            ix  = (c / (16 * SD)) % 4;
            nib = m_dig[4*ix +: 4];
            e.cs  = 4'hF;
            e.seg = 8'h00;
            if (pw <= m_bright && !m_blank[ix]) begin
                e.cs[ix] = 1'b0;
                e.seg    = {m_dp[ix], dec[nib]};
            end
            e.fs = ((c + 1) % FRAME) == 0;
            sb.push_back(e);
            if (e.fs) begin
                m_dig    = digitData;
                m_dp     = dpMask;
                m_blank  = blankMask;
                m_bright = brightness;
            end
            c++;
        end
    end

    // Monitor: compare away from the active edge.
    int unsigned ncyc = 0;
    int unsigned lastFs = 0;
    bit          haveFs = 0;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst) begin
            haveFs = 0;
        end else begin
            ncyc++;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                pops++;
                chk("SEG", {24'h0, SEG}, {24'h0, e.seg});
                chk("SEGCS", {28'h0, SEGCS}, {28'h0, e.cs});
                chk("frameStart", {31'h0, frameStart}, {31'h0, e.fs});
            end
            chk("cs_onehot", ($countones(~SEGCS) <= 1) ? 1 : 0, 1);
            if (SEGCS == 4'hF) chk("seg_dark", {24'h0, SEG}, 32'h0);
            if (frameStart) begin
                if (haveFs) chk("fs_period", ncyc - lastFs, FRAME);
                lastFs = ncyc;
                haveFs = 1;
            end
        end
    end

    task automatic step(input int unsigned n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_c(input int unsigned target);
        int unsigned guard;
        guard = 0;
        while (c < target && guard < 100000) begin
            step(1);
            guard++;
        end
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        digitData  = 16'h4321;
        brightness = 4'd15;
        wait_c(3 * FRAME + 40);
        digitData = 16'hFFFF;
        wait_c(5 * FRAME + 10);
        brightness = 4'd3;
        wait_c(7 * FRAME + 3);
        digitData  = 16'h8888;
        blankMask  = 4'b0100;
        dpMask     = 4'b0001;
        brightness = 4'd15;
        wait_c(9 * FRAME + 50);
        blankMask = 4'hF;
        wait_c(11 * FRAME + 5);
        blankMask = 4'h0;
        wait_c(12 * FRAME + 45);
        rst = 1'b1;
        #1;
        chk("rst_SEG", {24'h0, SEG}, 32'h0);
        chk("rst_SEGCS", {28'h0, SEGCS}, 32'hF);
        chk("rst_fs", {31'h0, frameStart}, 32'h0);
        step(3);
        rst = 1'b0;
        step(2 * FRAME);
        for (int i = 0; i < 20; i++) begin
            step($urandom_range(1, 300));
            digitData  = 16'($urandom);
            dpMask     = 4'($urandom);
            blankMask  = 4'($urandom & $urandom);
            brightness = 4'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                rst = 1'b1;
                #1;
                chk("rst_rand_SEGCS", {28'h0, SEGCS}, 32'hF);
                step(2);
                rst = 1'b0;
            end
        end
        step(2 * FRAME);
        step(2);
        chk("sb_drain", sb.size() <= 1 ? 1 : 0, 1);
        chk("pops_seen", pops > 3000 ? 1 : 0, 1);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg_scan_driver.md
SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter SUB_DIV, default 3125; it sets clock cycles per PWM sub-period, and legal values are >=1.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 SHALL have port digitData, input, 16 bits: hex nibble per digit; digit i uses bits [4i+3:4i].
REQ-005 SHALL have port dpMask, input, 4 bits: decimal point on, one bit per digit.
REQ-006 SHALL have port blankMask, input, 4 bits: 1 = digit i never selected.
REQ-007 SHALL have port brightness, input, 4 bits: PWM level; 15 = full on, 0 = 1/16 duty.
REQ-008 SHALL have port SEG, output, 8 bits, active-high: [6:0] = segments g..a (bit0=a), [7] = dp.
REQ-009 SHALL have port SEGCS, output, 4 bits, active-low one-hot digit select; bit i = digit i.
REQ-010 SHALL have port frameStart, output, 1 bit: one-cycle pulse at the start of each frame.

Function
REQ-011 SHALL implement subCnt, 0..SUB_DIV-1; subTick = (subCnt==SUB_DIV-1), after which subCnt wraps to 0. With SUB_DIV=1, subTick is high every cycle.
REQ-012 SHALL increment pwm[3:0] on subTick, wrapping 15->0.
REQ-013 SHALL advance index[1:0] on (subTick & pwm==15), wrapping 3->0.
- One digit slot = 16*SUB_DIV cycles; one frame = 64*SUB_DIV cycles.
REQ-014 SHALL, on frame end (subTick & pwm==15 & index==3), load shadow registers from digitData, dpMask, blankMask and brightness in the same edge.
- Inputs between frame ends have no visible effect.
REQ-015 SHALL register frameStart so it is high for exactly the first cycle in which index==0 after each frame end; it is not asserted after reset until the first frame end.
REQ-016 SHALL define on = (pwm <= brightShadow) & ~blankShadow[index].
REQ-017 SHALL, each cycle, register SEGCS <= on ? ~(4'b0001<<index) : 4'hF.
REQ-018 SHALL, each cycle, register SEG <= on ? {dpShadow[index], decode(nibble)} : 8'h00.
- Outputs lag counter state by exactly one cycle.
REQ-019 SHALL use this decode table (hex to [6:0]): 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07 8:7F 9:6F A:77 B:7C C:39 D:5E E:79 F:71.
REQ-020 SHALL never assert more than one SEGCS bit low in any cycle; SEG SHALL be 8'h00 whenever SEGCS==4'hF.
REQ-021 SHALL, when brightness changes mid-frame, apply the change only from the next frame; a digit is lit for (brightShadow+1)*SUB_DIV cycles at the start of its slot.
REQ-022 SHALL, with all blankShadow bits set, hold SEGCS=4'hF and SEG=8'h00 continuously while counters and frameStart still run.

Reset
REQ-023 SHALL, while rst is high, immediately force the following regardless of clk:
- subCnt, pwm, index = 0
- all shadows = 0
- SEG = 8'h00, SEGCS = 4'hF, frameStart = 0
REQ-024 SHALL, after rst deasserts, start at index 0, pwm 0.
- With zero shadows, digit0 shows "0" (SEG=3F) at duty 1/16 until the first frame end loads the inputs.
REQ-025 SHALL treat reset asserted mid-frame identically to power-on reset; no partial shadow load occurs.

Verification (SUB_DIV=2: slot 32 cycles, frame 128)
REQ-026 SHALL verify reset: assert rst mid-slot -> same cycle SEG=00, SEGCS=F, frameStart=0. After release, first lit cycle shows SEGCS=1110, SEG=3F for 2 cycles, then SEGCS=F for 30.
REQ-027 SHALL verify full-brightness scan: digitData=16'h4321, brightness=15, masks=0, applied before first frame end. After the frameStart pulse, for 32 cycles each:
- SEGCS=1110, SEG=06
- then 1101/5B
- then 1011/4F
- then 0111/66
REQ-028 SHALL verify PWM duty: brightness=3 -> per slot, SEGCS low for 8 cycles, then F for 24 cycles; frame period remains 128.
REQ-029 SHALL verify shadowing: change digitData 16'h4321->16'hFFFF during digit1 slot -> remaining slots of that frame still show 2,3,4; next frame shows SEG=71 on all digits.
REQ-030 SHALL verify masks: blankMask=0100, dpMask=0001, digitData=16'h8888 -> digit0 SEG=FF; digit2 slot SEGCS=F and SEG=00 for all 32 cycles; digits 1 and 3 show SEG=7F.
REQ-031 SHALL verify frameStart: pulse exactly every 128 cycles, one cycle wide, coincident with the first SEGCS=1110 output cycle minus one (outputs registered).
